// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous memory port among NREQ masters,
// returning read data one cycle after grant with a per-requester valid strobe.
module mem_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               mem_we,
    output logic [AW-1:0]      mem_raddr,
    output logic [AW-1:0]      mem_waddr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);
    localparam int PW = $clog2(NREQ);
    localparam logic [PW:0] N = (PW+1)'(NREQ);
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [PW-1:0] rr_ptr, rd_tag, winner, sel;
    logic [PW:0] idx;
    logic found, rd_pending;

    // Scan from the farthest offset down so the requester nearest rr_ptr wins last.
    always_comb begin
        winner = rr_ptr;
        found = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(k);
            idx = (idx >= N) ? idx - N : idx;
            if (req[idx[PW-1:0]]) begin
                winner = idx[PW-1:0];
                found = 1'b1;
            end
        end
    end

    assign sel = found ? winner : rr_ptr;
    assign gnt = found ? ONE << winner : '0;
    assign mem_we = found & req_we[winner];
    assign mem_raddr = req_addr[sel*AW +: AW];
    assign mem_waddr = req_addr[winner*AW +: AW];
    assign mem_wdata = req_wdata[winner*DW +: DW];
    assign rdata = mem_rdata;
    assign rvalid = rd_pending ? ONE << rd_tag : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            rd_pending <= 1'b0;
            rd_tag <= '0;
        end else begin
            rd_pending <= found & ~req_we[winner];
            if (found) begin
                rr_ptr <= (winner == LAST) ? '0 : winner + 1'b1;
                rd_tag <= winner;
            end
        end
    end
endmodule
